// File: rtl/flash_ctrl.sv
// Parallel NOR flash controller: one outstanding read or write, with timed CE/OE/WE strobes.
// All outputs come straight from registers; the comb process only computes next values.
module flash_ctrl #(
  parameter int RD_WAIT  = 8,
  parameter int WR_SETUP = 2,
  parameter int WR_PULSE = 4,
  parameter int WR_HOLD  = 2,
  parameter int WAIT_MAX = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [23:0] flash_addr,
  output logic [15:0] flash_dq_o,
  output logic        flash_dq_oe,
  input  logic [15:0] flash_dq_i,
  input  logic        flash_fwait_i,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACC,
    ST_RD_WAIT,
    ST_RSP,
    ST_WR_SU,
    ST_WR_PW,
    ST_WR_HD
  } state_t;

  // Phase counters are loaded with length-1 and count down to zero.
  localparam logic [15:0] C_RD = 16'(RD_WAIT - 1);
  localparam logic [15:0] C_SU = 16'(WR_SETUP - 1);
  localparam logic [15:0] C_PW = 16'(WR_PULSE - 1);
  localparam logic [15:0] C_HD = 16'(WR_HOLD - 1);
  localparam logic [15:0] C_WM = (WAIT_MAX > 0) ? 16'(WAIT_MAX - 1) : 16'd0;

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;
  logic [23:0] r_addr, w_addr;
  logic [15:0] r_dqO, w_dqO;
  logic        r_dqOe, w_dqOe;
  logic        r_ceN, w_ceN;
  logic        r_oeN, w_oeN;
  logic        r_weN, w_weN;
  logic        r_rspValid, w_rspValid;
  logic [15:0] r_rspData, w_rspData;
  logic        r_rspErr, w_rspErr;
  logic        r_reqReady, w_reqReady;
  logic        r_busy, w_busy;
  logic        w_sample, w_sampleErr;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_addr      = r_addr;
    w_dqO       = r_dqO;
    w_dqOe      = r_dqOe;
    w_ceN       = r_ceN;
    w_oeN       = r_oeN;
    w_weN       = r_weN;
    w_rspValid  = r_rspValid;
    w_rspData   = r_rspData;
    w_rspErr    = r_rspErr;
    w_reqReady  = r_reqReady;
    w_busy      = r_busy;
    w_sample    = 1'b0;
    w_sampleErr = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_reqReady = 1'b1;
        if (req_valid && r_reqReady) begin
          w_reqReady = 1'b0;
          w_busy     = 1'b1;
          w_addr     = req_addr;
          w_ceN      = 1'b0;
          if (req_write) begin
            w_state = ST_WR_SU;
            w_dqO   = req_wdata;
            w_dqOe  = 1'b1;
            w_weN   = 1'b1;
            w_oeN   = 1'b1;
            w_cnt   = C_SU;
          end else begin
            w_state = ST_RD_ACC;
            w_dqOe  = 1'b0;
            w_oeN   = 1'b0;
            w_cnt   = C_RD;
          end
        end
      end
      ST_RD_ACC: begin
        if (r_cnt != 16'd0) begin
          w_cnt = r_cnt - 16'd1;
        end else if (!flash_fwait_i) begin
          w_sample = 1'b1;
        end else if (WAIT_MAX == 0) begin
          w_sample    = 1'b1;
          w_sampleErr = 1'b1;
        end else begin
          w_state = ST_RD_WAIT;
          w_cnt   = 16'd0;
        end
      end
      // Counts up the extra cycles spent waiting; gives up after WAIT_MAX of them.
      ST_RD_WAIT: begin
        if (!flash_fwait_i) begin
          w_sample = 1'b1;
        end else if (r_cnt == C_WM) begin
          w_sample    = 1'b1;
          w_sampleErr = 1'b1;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          w_rspValid = 1'b0;
          w_reqReady = 1'b1;
          w_busy     = 1'b0;
          w_state    = ST_IDLE;
        end
      end
      ST_WR_SU: begin
        if (r_cnt != 16'd0) begin
          w_cnt = r_cnt - 16'd1;
        end else begin
          w_state = ST_WR_PW;
          w_weN   = 1'b0;
          w_cnt   = C_PW;
        end
      end
      ST_WR_PW: begin
        if (r_cnt != 16'd0) begin
          w_cnt = r_cnt - 16'd1;
        end else begin
          w_state = ST_WR_HD;
          w_weN   = 1'b1;
          w_cnt   = C_HD;
        end
      end
      ST_WR_HD: begin
        if (r_cnt != 16'd0) begin
          w_cnt = r_cnt - 16'd1;
        end else begin
          w_state    = ST_IDLE;
          w_ceN      = 1'b1;
          w_dqOe     = 1'b0;
          w_reqReady = 1'b1;
          w_busy     = 1'b0;
          w_cnt      = 16'd0;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    if (w_sample) begin
      w_state    = ST_RSP;
      w_rspValid = 1'b1;
      w_rspData  = flash_dq_i;
      w_rspErr   = w_sampleErr;
      w_ceN      = 1'b1;
      w_oeN      = 1'b1;
      w_cnt      = 16'd0;
    end
  end

  // Reset aborts any transaction outright, including a WE pulse in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 16'd0;
      r_addr     <= 24'd0;
      r_dqO      <= 16'd0;
      r_dqOe     <= 1'b0;
      r_ceN      <= 1'b1;
      r_oeN      <= 1'b1;
      r_weN      <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspData  <= 16'd0;
      r_rspErr   <= 1'b0;
      r_reqReady <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_addr     <= w_addr;
      r_dqO      <= w_dqO;
      r_dqOe     <= w_dqOe;
      r_ceN      <= w_ceN;
      r_oeN      <= w_oeN;
      r_weN      <= w_weN;
      r_rspValid <= w_rspValid;
      r_rspData  <= w_rspData;
      r_rspErr   <= w_rspErr;
      r_reqReady <= w_reqReady;
      r_busy     <= w_busy;
    end
  end

  assign req_ready   = r_reqReady;
  assign rsp_valid   = r_rspValid;
  assign rsp_data    = r_rspData;
  assign rsp_err     = r_rspErr;
  assign flash_addr  = r_addr;
  assign flash_dq_o  = r_dqO;
  assign flash_dq_oe = r_dqOe;
  assign flash_ce_n  = r_ceN;
  assign flash_oe_n  = r_oeN;
  assign flash_we_n  = r_weN;
  assign busy        = r_busy;

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: directed vector table, reset-abort sequence and
// randomized reads/writes judged against a cycle-count model of the flash timing rules.
module tb_flash_ctrl;

  localparam int RD_WAIT  = 8;
  localparam int WR_SETUP = 2;
  localparam int WR_PULSE = 4;
  localparam int WR_HOLD  = 2;
  localparam int WAIT_MAX = 255;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic [23:0] flash_addr;
  logic [15:0] flash_dq_o, flash_dq_i;
  logic        flash_dq_oe, flash_fwait_i, flash_ce_n, flash_oe_n, flash_we_n, busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          isWrite;
    logic [23:0] addr;
    logic [15:0] data;
    int          extra;
    int          rspDelay;
    int          expLat;
    bit          expErr;
  } vec_t;

  vec_t vecs[8];

  flash_ctrl #(
    .RD_WAIT(RD_WAIT), .WR_SETUP(WR_SETUP), .WR_PULSE(WR_PULSE),
    .WR_HOLD(WR_HOLD), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
    .flash_dq_i(flash_dq_i), .flash_fwait_i(flash_fwait_i),
    .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read timing rule: sample once fwait is low after RD_WAIT, or give up after WAIT_MAX extras.
  function automatic void readModel(input int extra, output int lat, output bit err);
    if (extra <= WAIT_MAX) begin
      lat = RD_WAIT + extra + 1;
      err = 1'b0;
    end else begin
      lat = RD_WAIT + WAIT_MAX + 1;
      err = 1'b1;
    end
  endfunction

  task automatic waitReady();
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) @(negedge CLK);
    checkOutput("waitReady", 32'(req_ready), 32'd1);
  endtask

  // Offers one request for a single edge; returns at the negedge right after the accept edge.
  task automatic applyStimulus(input bit isWrite, input logic [23:0] addr, input logic [15:0] data);
    waitReady();
    req_valid = 1'b1;
    req_write = isWrite;
    req_addr  = addr;
    req_wdata = data;
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic runRead(input string tag, input logic [23:0] addr, input logic [15:0] fixedData,
                         input bit useFixed, input int extra, input int rspDelay,
                         input int expLat, input bit expErr);
    logic [15:0] dqAt [0:1023];
    logic [15:0] expData;
    int j;
    int jv;
    flash_fwait_i = 1'b0;
    flash_dq_i    = useFixed ? fixedData : 16'($urandom);
    rsp_ready     = (rspDelay == 0);
    applyStimulus(1'b0, addr, 16'($urandom));
    j  = 0;
    jv = -1;
    while (jv < 0 && j < expLat + 10) begin
      if (rsp_valid === 1'b1) begin
        jv = j;
      end else begin
        checkOutput({tag, ".ceN"}, 32'(flash_ce_n), 32'd0);
        checkOutput({tag, ".oeN"}, 32'(flash_oe_n), 32'd0);
        checkOutput({tag, ".dqOe"}, 32'(flash_dq_oe), 32'd0);
        checkOutput({tag, ".addr"}, 32'(flash_addr), 32'(addr));
        checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
        checkOutput({tag, ".reqReady"}, 32'(req_ready), 32'd0);
        flash_fwait_i = (extra > 0) && (j + 1 < RD_WAIT + extra);
        flash_dq_i    = useFixed ? fixedData : 16'($urandom);
        dqAt[j + 1]   = flash_dq_i;
        @(negedge CLK);
        j++;
      end
    end
    flash_fwait_i = 1'b0;
    checkOutput({tag, ".latency"}, 32'(jv + 1), 32'(expLat));
    if (jv < 0) return;
    expData = useFixed ? fixedData : dqAt[expLat - 1];
    checkOutput({tag, ".rspData"}, 32'(rsp_data), 32'(expData));
    checkOutput({tag, ".rspErr"}, 32'(rsp_err), 32'(expErr));
    checkOutput({tag, ".ceNRsp"}, 32'(flash_ce_n), 32'd1);
    checkOutput({tag, ".oeNRsp"}, 32'(flash_oe_n), 32'd1);
    checkOutput({tag, ".busyRsp"}, 32'(busy), 32'd1);
    if (rspDelay == 0) begin
      @(negedge CLK);
      checkOutput({tag, ".rspDone"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".readyAfter"}, 32'(req_ready), 32'd1);
      checkOutput({tag, ".idleBusy"}, 32'(busy), 32'd0);
      rsp_ready = 1'b0;
    end else begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = ~addr;
      for (int i = 0; i < rspDelay; i++) begin
        @(negedge CLK);
        checkOutput({tag, ".holdValid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, ".holdData"}, 32'(rsp_data), 32'(expData));
        checkOutput({tag, ".holdErr"}, 32'(rsp_err), 32'(expErr));
        checkOutput({tag, ".holdReady"}, 32'(req_ready), 32'd0);
        checkOutput({tag, ".holdCeN"}, 32'(flash_ce_n), 32'd1);
        checkOutput({tag, ".holdAddr"}, 32'(flash_addr), 32'(addr));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      checkOutput({tag, ".rspDone"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".readyAfter"}, 32'(req_ready), 32'd1);
      checkOutput({tag, ".addrHeld"}, 32'(flash_addr), 32'(addr));
    end
  endtask

  task automatic runWrite(input string tag, input logic [23:0] addr, input logic [15:0] data,
                          input int expTotal);
    applyStimulus(1'b1, addr, data);
    for (int j = 0; j <= expTotal; j++) begin
      if (j > 0) @(negedge CLK);
      checkOutput({tag, ".noRsp"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".noContention"}, 32'(!flash_oe_n && flash_dq_oe), 32'd0);
      checkOutput({tag, ".addr"}, 32'(flash_addr), 32'(addr));
      checkOutput({tag, ".dqO"}, 32'(flash_dq_o), 32'(data));
      if (j < expTotal) begin
        checkOutput({tag, ".dqOe"}, 32'(flash_dq_oe), 32'd1);
        checkOutput({tag, ".ceN"}, 32'(flash_ce_n), 32'd0);
        checkOutput({tag, ".oeN"}, 32'(flash_oe_n), 32'd1);
        checkOutput({tag, ".weN"}, 32'(flash_we_n),
                    32'(!(j >= WR_SETUP && j < WR_SETUP + WR_PULSE)));
        checkOutput({tag, ".reqReady"}, 32'(req_ready), 32'd0);
      end else begin
        checkOutput({tag, ".dqOeEnd"}, 32'(flash_dq_oe), 32'd0);
        checkOutput({tag, ".ceNEnd"}, 32'(flash_ce_n), 32'd1);
        checkOutput({tag, ".weNEnd"}, 32'(flash_we_n), 32'd1);
        checkOutput({tag, ".readyEnd"}, 32'(req_ready), 32'd1);
        checkOutput({tag, ".busyEnd"}, 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".reqReady"}, 32'(req_ready), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".rspValid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".rspData"}, 32'(rsp_data), 32'd0);
    checkOutput({tag, ".rspErr"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, ".ceN"}, 32'(flash_ce_n), 32'd1);
    checkOutput({tag, ".oeN"}, 32'(flash_oe_n), 32'd1);
    checkOutput({tag, ".weN"}, 32'(flash_we_n), 32'd1);
    checkOutput({tag, ".dqOe"}, 32'(flash_dq_oe), 32'd0);
    checkOutput({tag, ".addr"}, 32'(flash_addr), 32'd0);
    checkOutput({tag, ".dqO"}, 32'(flash_dq_o), 32'd0);
  endtask

  initial begin
    int lat;
    bit err;
    int extra;
    int r;

    vecs[0] = '{1'b0, 24'h012345, 16'hA5C3, 0,    0,  9,   1'b0};
    vecs[1] = '{1'b0, 24'h0ABCDE, 16'h5A5A, 5,    0,  14,  1'b0};
    vecs[2] = '{1'b0, 24'hFFFFFF, 16'h1357, 1000, 0,  264, 1'b1};
    vecs[3] = '{1'b1, 24'h000010, 16'h1234, 0,    0,  8,   1'b0};
    vecs[4] = '{1'b0, 24'h123456, 16'hBEEF, 0,    20, 9,   1'b0};
    vecs[5] = '{1'b0, 24'h000001, 16'h0F0F, 255,  1,  264, 1'b0};
    vecs[6] = '{1'b0, 24'h800000, 16'hF00D, 256,  2,  264, 1'b1};
    vecs[7] = '{1'b1, 24'hFFFFFF, 16'hFFFF, 0,    0,  8,   1'b0};

    RST = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; flash_dq_i = '0; flash_fwait_i = 1'b0;
    repeat (3) @(negedge CLK);
    checkResetState("reset");
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("reset.readyFirstEdge", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].isWrite)
        runWrite($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].expLat);
      else
        runRead($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, 1'b1, vecs[i].extra,
                vecs[i].rspDelay, vecs[i].expLat, vecs[i].expErr);
    end

    // Reset in the middle of the WE pulse must kill the strobe and the transaction.
    applyStimulus(1'b1, 24'h00ABCD, 16'hCAFE);
    repeat (3) @(negedge CLK);
    checkOutput("rstWr.weLowBefore", 32'(flash_we_n), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    checkResetState("rstWr");
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("rstWr.readyAfter", 32'(req_ready), 32'd1);
    checkOutput("rstWr.noRsp", 32'(rsp_valid), 32'd0);
    runRead("postRst", 24'h0C0FFE, 16'h7E57, 1'b1, 0, 0, 9, 1'b0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        runWrite($sformatf("rndW%0d", i), 24'($urandom), 16'($urandom),
                 WR_SETUP + WR_PULSE + WR_HOLD);
      end else begin
        r = $urandom_range(0, 9);
        if (r < 5)       extra = 0;
        else if (r < 8)  extra = $urandom_range(1, 12);
        else if (r == 8) extra = $urandom_range(250, 256);
        else             extra = 400;
        readModel(extra, lat, err);
        runRead($sformatf("rndR%0d", i), 24'($urandom), 16'h0, 1'b0, extra,
                $urandom_range(0, 3), lat, err);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
